apb_sysbus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single APB bridge system_bus between N_REQ independent requesters (CPU model, DMA, test ports).
- Grants one requester at a time and packs its request into the 21-bit system_bus word.
- The bridge/slave has no PREADY, so the block times each transfer with a fixed cycle count, then captures PRDATA and returns a one-cycle done pulse to the winner.
- Sits directly in front of the bridge's system_bus input and observes the shared PRDATA.

---
 rtl/apb_arb_pkg.sv | 37 +++
 rtl/apb_sysbus_arbiter_if.sv | 32 +++
 rtl/apb_rr_pick.sv | 29 ++
 rtl/apb_sysbus_arbiter.sv | 139 +++++++++++++
 tb/tb_apb_sysbus_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and system_bus field layout for the APB system_bus arbiter.
// The lock option in the other files is enabled by defining APB_ARB_LOCK_EN.
package apb_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

    localparam int SYSBUS_W  = 21;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int START_BIT = 20;
    localparam int WRITE_BIT = 19;
    localparam int ADDR_MSB  = 18;
    localparam int ADDR_LSB  = 11;
    localparam int WDATA_MSB = 10;
    localparam int WDATA_LSB = 3;
    localparam int TAG_MSB   = 2;
    localparam int TAG_LSB   = 0;
    localparam int LOCK_MAX  = 4;

    function automatic logic [SYSBUS_W-1:0] pack_sysbus(
        input logic              start,
        input logic              write,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata,
        input logic [2:0]        tag
    );
        logic [SYSBUS_W-1:0] w;
        w                      = '0;
        w[START_BIT]           = start;
        w[WRITE_BIT]           = write;
        w[ADDR_MSB:ADDR_LSB]   = addr;
        w[WDATA_MSB:WDATA_LSB] = wdata;
        w[TAG_MSB:TAG_LSB]     = tag;
        return w;
    endfunction

endpackage

// File: rtl/apb_sysbus_arbiter_if.sv
// Requester/bridge signal bundle for apb_sysbus_arbiter.
// req_lock exists only when APB_ARB_LOCK_EN is defined.
interface apb_sysbus_arbiter_if import apb_arb_pkg::*; #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
`ifdef APB_ARB_LOCK_EN
    logic [N_REQ-1:0]        req_lock;
`endif
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic [DATA_W-1:0]       rdata;
    logic                    busy;
    logic [SYSBUS_W-1:0]     sysbus;
    logic [DATA_W-1:0]       PRDATA;

`ifdef APB_ARB_LOCK_EN
    modport master (output req, req_write, req_addr, req_wdata, req_lock, PRDATA,
                    input  gnt, done, rdata, busy, sysbus);
    modport slave  (input  req, req_write, req_addr, req_wdata, req_lock, PRDATA,
                    output gnt, done, rdata, busy, sysbus);
`else
    modport master (output req, req_write, req_addr, req_wdata, PRDATA,
                    input  gnt, done, rdata, busy, sysbus);
    modport slave  (input  req, req_write, req_addr, req_wdata, PRDATA,
                    output gnt, done, rdata, busy, sysbus);
`endif

endinterface

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module apb_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx
);
    always_comb begin
        int               j;
        logic [IDX_W-1:0] jj;
        logic             found;
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            jj = IDX_W'(j);
            if (!found && req[jj]) begin
                found      = 1'b1;
                win_oh[jj] = 1'b1;
                win_idx    = jj;
            end
        end
    end
endmodule

// File: rtl/apb_sysbus_arbiter.sv
// Round-robin arbiter/sequencer sharing one PREADY-less APB bridge system_bus.
// Define APB_ARB_LOCK_EN to add req_lock back-to-back access (bounded by LOCK_MAX).
module apb_sysbus_arbiter import apb_arb_pkg::*; #(
    parameter int N_REQ       = 4,
    parameter int XFER_CYCLES = 2
) (
    input logic                 PCLK,
    input logic                 RESET,
    apb_sysbus_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, win_idx_q, pick_idx, latch_idx;
    logic [N_REQ-1:0]     win_oh_q, pick_oh, latch_oh;
    logic [3:0]           cnt_q;
    logic                 h_write;
    logic [ADDR_W-1:0]    h_addr;
    logic [DATA_W-1:0]    h_wdata;
    logic [DATA_W-1:0]    rdata_q;
    logic                 latch_en, ptr_adv, rd_cap;
    logic [N_REQ-1:0]     gnt, done;
    logic [SYSBUS_W-1:0]  sysbus;
`ifdef APB_ARB_LOCK_EN
    logic [2:0]           lock_cnt_q;
    logic                 lock_keep;
`endif

    apb_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx)
    );

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_idx_q <= '0;
            win_oh_q  <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
`ifdef APB_ARB_LOCK_EN
            lock_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                win_idx_q <= latch_idx;
                win_oh_q  <= latch_oh;
            end
            if (state_q == ISSUE)
                cnt_q <= 4'(XFER_CYCLES);
            else if (state_q == WAIT)
                cnt_q <= cnt_q - 4'd1;
            if (ptr_adv)
                ptr_q <= (win_idx_q == IDX_W'(N_REQ - 1)) ? '0 : win_idx_q + IDX_W'(1);
            if (rd_cap)
                rdata_q <= bus.PRDATA;
`ifdef APB_ARB_LOCK_EN
            if (lock_keep)
                lock_cnt_q <= lock_cnt_q + 3'd1;
            else if (ptr_adv)
                lock_cnt_q <= '0;
`endif
        end
    end

    // Holding registers snapshot the winner's fields; nothing observes them outside a grant.
    always_ff @(posedge PCLK) begin
        if (latch_en) begin
            h_write <= bus.req_write[latch_idx];
            h_addr  <= bus.req_addr[latch_idx*ADDR_W +: ADDR_W];
            h_wdata <= bus.req_wdata[latch_idx*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        latch_en  = 1'b0;
        latch_idx = pick_idx;
        latch_oh  = pick_oh;
        ptr_adv   = 1'b0;
        rd_cap    = 1'b0;
        gnt       = '0;
        done      = '0;
        sysbus    = '0;
`ifdef APB_ARB_LOCK_EN
        lock_keep = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    latch_en = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                gnt     = win_oh_q;
                sysbus  = pack_sysbus(1'b1, h_write, h_addr, h_wdata, 3'(win_idx_q));
                state_d = WAIT;
            end
            WAIT: begin
                gnt    = win_oh_q;
                sysbus = pack_sysbus(1'b0, h_write, h_addr, h_wdata, 3'(win_idx_q));
                if (cnt_q <= 4'd1) state_d = DONE;
            end
            DONE: begin
                gnt     = win_oh_q;
                done    = win_oh_q;
                sysbus  = pack_sysbus(1'b0, h_write, h_addr, h_wdata, 3'(win_idx_q));
                rd_cap  = ~h_write;
                ptr_adv = 1'b1;
                state_d = IDLE;
`ifdef APB_ARB_LOCK_EN
                // Locked winner re-issues directly; the run is capped at LOCK_MAX transfers.
                if (bus.req_lock[win_idx_q] && bus.req[win_idx_q] &&
                    lock_cnt_q < 3'(LOCK_MAX - 1)) begin
                    lock_keep = 1'b1;
                    ptr_adv   = 1'b0;
                    latch_en  = 1'b1;
                    latch_idx = win_idx_q;
                    latch_oh  = win_oh_q;
                    state_d   = ISSUE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt    = gnt;
    assign bus.done   = done;
    assign bus.sysbus = sysbus;
    assign bus.rdata  = rdata_q;
    assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_apb_sysbus_arbiter.sv
// Directed bench for apb_sysbus_arbiter: vector table plus multi-cycle corner sequences.
module tb_apb_sysbus_arbiter;
    import apb_arb_pkg::*;

    localparam int N_REQ = 4;
    localparam int XFER  = 2;

    logic PCLK = 1'b0;
    logic RESET;
    always #5 PCLK = ~PCLK;

    apb_sysbus_arbiter_if #(.N_REQ(N_REQ)) bus();

    apb_sysbus_arbiter #(.N_REQ(N_REQ), .XFER_CYCLES(XFER)) dut (
        .PCLK  (PCLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        int          idx;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  prdata;
        logic [20:0] exp_bus;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vt[5];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   iss_tag[16];
    int   iss_cyc[16];
    int   got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
        bus.req_write[i]       = w;
        bus.req_addr[i*8 +: 8]  = a;
        bus.req_wdata[i*8 +: 8] = d;
        bus.req[i]             = 1'b1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    // Records ISSUE cycles (tag, cycle offset); 'late' requests join after the first ISSUE.
    task automatic collect(input int n, input logic [N_REQ-1:0] late, output int cnt);
        cnt = 0;
        for (int c = 0; c < 200 && cnt < n; c++) begin
            tick();
            if (bus.sysbus[20]) begin
                iss_tag[cnt] = int'(bus.sysbus[2:0]);
                iss_cyc[cnt] = c;
                cnt++;
                if (cnt == 1) bus.req = bus.req | late;
            end
        end
    endtask

    task automatic drain();
        bus.req = '0;
        for (int c = 0; c < 50 && bus.busy; c++) tick();
        check("drain_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic run_one(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
        set_req(i, w, a, d);
        for (int c = 0; c < 2 + XFER; c++) tick();
        check("aux_done", 32'(bus.done), 32'(4'b0001 << i));
        bus.req[i] = 1'b0;
        tick();
    endtask

    initial begin
        vt[0] = '{2, 1'b1, 8'h1C, 8'hA5, 8'h3C, 21'h18E52A, 8'h00};
        vt[1] = '{1, 1'b0, 8'h1C, 8'h00, 8'hA5, 21'h10E001, 8'hA5};
        vt[2] = '{3, 1'b1, 8'hFF, 8'h5A, 8'h11, 21'h1FFAD3, 8'hA5};
        vt[3] = '{0, 1'b0, 8'h00, 8'hFF, 8'h00, 21'h1007F8, 8'h00};
        vt[4] = '{2, 1'b0, 8'h80, 8'h01, 8'hC3, 21'h14000A, 8'hC3};

        RESET         = 1'b1;
        bus.req       = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PRDATA    = 8'h00;
`ifdef APB_ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
        tick();
        tick();
        RESET = 1'b0;
        check("rst_gnt",    32'(bus.gnt),    32'd0);
        check("rst_done",   32'(bus.done),   32'd0);
        check("rst_rdata",  32'(bus.rdata),  32'd0);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_sysbus", 32'(bus.sysbus), 32'd0);

        for (int v = 0; v < 5; v++) begin
            bus.PRDATA = 8'hEE;
            set_req(vt[v].idx, vt[v].wr, vt[v].addr, vt[v].wdata);
            tick();
            check("issue_sysbus", 32'(bus.sysbus), 32'(vt[v].exp_bus));
            check("issue_gnt",    32'(bus.gnt),    32'(4'b0001 << vt[v].idx));
            check("issue_busy",   32'(bus.busy),   32'd1);
            bus.req_addr[vt[v].idx*8 +: 8] = 8'h66;
            for (int w = 0; w < XFER; w++) begin
                tick();
                check("wait_sysbus", 32'(bus.sysbus), 32'(vt[v].exp_bus & 21'h0FFFFF));
                check("wait_done",   32'(bus.done),   32'd0);
            end
            tick();
            check("done_pulse", 32'(bus.done), 32'(4'b0001 << vt[v].idx));
            check("done_gnt",   32'(bus.gnt),  32'(4'b0001 << vt[v].idx));
            bus.PRDATA        = vt[v].prdata;
            bus.req[vt[v].idx] = 1'b0;
            tick();
            check("idle_gnt",    32'(bus.gnt),    32'd0);
            check("idle_done",   32'(bus.done),   32'd0);
            check("idle_busy",   32'(bus.busy),   32'd0);
            check("idle_sysbus", 32'(bus.sysbus), 32'd0);
            check("idle_rdata",  32'(bus.rdata),  32'(vt[v].exp_rdata));
        end

        // Request withdrawn right after ISSUE still completes.
        set_req(3, 1'b1, 8'h42, 8'h99);
        tick();
        check("wd_issue_tag", 32'(bus.sysbus[2:0]), 32'd3);
        bus.req[3] = 1'b0;
        tick();
        check("wd_wait_tag", 32'(bus.sysbus[2:0]), 32'd3);
        check("wd_wait_gnt", 32'(bus.gnt), 32'h8);
        tick();
        tick();
        check("wd_done", 32'(bus.done), 32'h8);
        tick();
        tick();
        check("wd_no_regrant", 32'(bus.busy), 32'd0);
        check("wd_rdata_kept", 32'(bus.rdata), 32'hC3);

        // Leave the pointer at 1, then reset in the middle of a read.
        run_one(0, 1'b1, 8'h01, 8'h02);
        set_req(1, 1'b0, 8'h10, 8'h00);
        bus.PRDATA = 8'h77;
        tick();
        tick();
        RESET = 1'b1;
        tick();
        RESET      = 1'b0;
        bus.req[1] = 1'b0;
        check("rw_sysbus", 32'(bus.sysbus), 32'd0);
        check("rw_gnt",    32'(bus.gnt),    32'd0);
        check("rw_done",   32'(bus.done),   32'd0);
        check("rw_busy",   32'(bus.busy),   32'd0);
        check("rw_rdata",  32'(bus.rdata),  32'd0);
        tick();
        check("rw_no_done", 32'(bus.done), 32'd0);
        set_req(0, 1'b0, 8'h20, 8'h00);
        set_req(1, 1'b0, 8'h21, 8'h00);
        tick();
        check("rw_first_gnt", 32'(bus.gnt), 32'h1);
        for (int c = 0; c < XFER + 1; c++) tick();
        check("rw_first_done", 32'(bus.done), 32'h1);
        bus.req[0] = 1'b0;
        tick();
        tick();
        check("rw_second_gnt", 32'(bus.gnt), 32'h2);
        drain();

        // Fairness with all requesters held.
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 8'(8'h30 + i), 8'(i));
        collect(8, '0, got);
        check("fair_count", 32'(got), 32'd8);
        for (int i = 0; i < 8; i++) check("fair_tag", 32'(iss_tag[i]), 32'(i % 4));
        for (int i = 1; i < 8; i++) check("fair_space", 32'(iss_cyc[i] - iss_cyc[i-1]), 32'(XFER + 3));
        drain();

`ifdef APB_ARB_LOCK_EN
        do_reset();
        set_req(1, 1'b1, 8'h50, 8'h0F);
        bus.req_write[0]  = 1'b1;
        bus.req_addr[7:0] = 8'h60;
        bus.req_lock[1]   = 1'b1;
        collect(5, 4'b0001, got);
        check("lock_count", 32'(got), 32'd5);
        for (int i = 0; i < 4; i++) check("lock_tag", 32'(iss_tag[i]), 32'd1);
        check("lock_release_tag", 32'(iss_tag[4]), 32'd0);
        for (int i = 1; i < 4; i++) check("lock_space", 32'(iss_cyc[i] - iss_cyc[i-1]), 32'(XFER + 2));
        check("lock_release_space", 32'(iss_cyc[4] - iss_cyc[3]), 32'(XFER + 3));
        bus.req_lock = '0;
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
